// File: rtl/weight_pkg.sv
// weight_pkg: shared definitions for the weight packer.
//   - default DATA_W / LANES / TOTAL values
//   - FSM state encoding
//   - idx_w(): width of an index into n items (at least 1 bit)
package weight_pkg;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_LANES  = 4;
  localparam int DEF_TOTAL  = 12288;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_lane_reg.sv
// weight_lane_reg: LANES x DATA_W lane register with synchronous clear and
// indexed write. Lane k occupies bits [k*DATA_W +: DATA_W] of data.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears all lanes)
//   clr               clear all lanes (wins over wr_en)
//   wr_en, wr_idx     write wr_data into lane wr_idx
//   wr_data           lane value
//   data              packed lane contents
module weight_lane_reg
  import weight_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  localparam int IDX_W = idx_w(LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [LANES*DATA_W-1:0]   data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clr) begin
      data <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_idx == IDX_W'(k)) data[k*DATA_W +: DATA_W] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/weight_packer.sv
// weight_packer: packs a load of TOTAL samples of DATA_W bits into words of
// LANES samples (lane 0 = first accepted sample). A final partial word keeps
// its unfilled lanes zero.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      pulse to begin a load (ignored while busy)
//   in_valid/in_ready/in_data  sample input handshake
//   out_valid/out_ready        packed word handshake
//   out_data, out_last         packed word, flag for the word holding sample TOTAL-1
//   busy, done                 status (FILL/HOLD, DONE)
//   sample_cnt                 samples accepted in the current load
//   checksum                   only with WEIGHT_PACKER_CHECKSUM_EN: 16-bit running
//                              sum of accepted samples
// Optional feature macro: WEIGHT_PACKER_CHECKSUM_EN
//
// state | meaning
// IDLE  | after reset, waiting for start
// FILL  | accepting samples into the lane register
// HOLD  | packed word offered on out_data, input stalled
// DONE  | load complete, waiting for start
module weight_packer
  import weight_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int TOTAL  = DEF_TOTAL,
  localparam int CNT_W  = $clog2(TOTAL + 1),
  localparam int LANE_W = idx_w(LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          sample_cnt
`ifdef WEIGHT_PACKER_CHECKSUM_EN
  ,
  output logic [15:0]               checksum
`endif
);

  state_t              state;
  logic [LANE_W-1:0]   lane;
  logic                start_ok;
  logic                accept;
  logic                last_lane;
  logic                last_sample;
  logic                lane_clr;

  assign start_ok    = start && (state == ST_IDLE || state == ST_DONE);
  assign accept      = (state == ST_FILL) && in_valid;
  assign last_lane   = (lane == LANE_W'(LANES - 1));
  assign last_sample = (sample_cnt == CNT_W'(TOTAL - 1));
  // lanes are wiped at the start of a load and whenever a non-final word leaves
  assign lane_clr    = start_ok || (state == ST_HOLD && out_ready && !out_last);

  weight_lane_reg #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_lane_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (lane_clr),
    .wr_en   (accept),
    .wr_idx  (lane),
    .wr_data (in_data),
    .data    (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lane       <= '0;
      sample_cnt <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_FILL;
            lane       <= '0;
            sample_cnt <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        ST_FILL: begin
          if (in_valid) begin
            lane       <= lane + 1'b1;
            sample_cnt <= sample_cnt + 1'b1;
            if (last_lane || last_sample) begin
              state     <= ST_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_last  <= last_sample;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= ST_FILL;
              lane     <= '0;
              in_ready <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WEIGHT_PACKER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + 16'(in_data);
    end
  end
`endif

endmodule

// File: tb/tb_weight_packer.sv
// tb_weight_packer: two packers (TOTAL=8 and TOTAL=6, LANES=4, DATA_W=6) on
// shared inputs, checked against a sample/word-count model of a load.
module tb_weight_packer;

  localparam int DW = 6;
  localparam int LN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [5:0]  in_data;
  logic        out_ready;
  logic [1:0]  irdy, ov, last, busy, done;
  logic [23:0] od [2];
  logic [3:0]  sc_a;
  logic [2:0]  sc_b;
`ifdef WEIGHT_PACKER_CHECKSUM_EN
  logic [15:0] cs [2];
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: accepted samples, words consumed, load started, running sum
  logic [5:0] acc [2][8];
  int         nacc [2];
  int         nw [2];
  bit         started [2];
  int         sum [2];

  always #5 clk = ~clk;

  weight_packer #(.DATA_W(DW), .LANES(LN), .TOTAL(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(irdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_last(last[0]),
    .out_ready(out_ready), .busy(busy[0]), .done(done[0]), .sample_cnt(sc_a)
`ifdef WEIGHT_PACKER_CHECKSUM_EN
    , .checksum(cs[0])
`endif
  );

  weight_packer #(.DATA_W(DW), .LANES(LN), .TOTAL(6)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(irdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_last(last[1]),
    .out_ready(out_ready), .busy(busy[1]), .done(done[1]), .sample_cnt(sc_b)
`ifdef WEIGHT_PACKER_CHECKSUM_EN
    , .checksum(cs[1])
`endif
  );

  function automatic int tot_of(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic int nwords(input int d);
    return (tot_of(d) + LN - 1) / LN;
  endfunction

  function automatic bit m_active(input int d);
    return started[d] && (nw[d] < nwords(d));
  endfunction

  // a word is pending once all samples it needs have been accepted
  function automatic bit m_pending(input int d);
    int need;
    need = (nw[d] + 1) * LN;
    if (need > tot_of(d)) need = tot_of(d);
    return m_active(d) && (nacc[d] >= need);
  endfunction

  function automatic logic [23:0] m_word(input int d);
    logic [23:0] w;
    w = '0;
    for (int k = 0; k < LN; k++) begin
      if (nw[d] * LN + k < nacc[d]) w[k*DW +: DW] = acc[d][nw[d] * LN + k];
    end
    return w;
  endfunction

  function automatic int scv(input int d);
    return (d == 0) ? int'(sc_a) : int'(sc_b);
  endfunction

  // applies the current inputs to the model, then advances to the next negedge
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        started[d] = 1'b0; nacc[d] = 0; nw[d] = 0; sum[d] = 0;
      end else if (start && !m_active(d)) begin
        started[d] = 1'b1; nacc[d] = 0; nw[d] = 0; sum[d] = 0;
      end else if (m_active(d)) begin
        if (m_pending(d)) begin
          if (out_ready) nw[d]++;
        end else if (in_valid) begin
          acc[d][nacc[d]] = in_data;
          nacc[d]++;
          sum[d] += int'(in_data);
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      total++; if ({ov[d], irdy[d], last[d], busy[d], done[d]} !== 5'b0) begin bad++; $display("FAIL reset_flags d=%0d got=%b exp=00000", d, {ov[d], irdy[d], last[d], busy[d], done[d]}); end
      total++; if (od[d] !== 24'h0) begin bad++; $display("FAIL reset_data d=%0d got=%h exp=0", d, od[d]); end
      total++; if (scv(d) !== 0) begin bad++; $display("FAIL reset_cnt d=%0d got=%0d exp=0", d, scv(d)); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [23:0] wd [2][2];
    logic        wl [2][2];
    int nc [2];
    int ov_cyc [2][2];
    int done_cyc [2];
    int s_cyc;
    nc = '{0, 0}; done_cyc = '{-1, -1};
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    s_cyc = cyc;
    tick();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 40 && done_cyc[0] < 0; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (ov[d] && nc[d] < 2) begin
          wd[d][nc[d]] = od[d]; wl[d][nc[d]] = last[d]; ov_cyc[d][nc[d]] = cyc; nc[d]++;
        end
        if (done[d] && done_cyc[d] < 0) done_cyc[d] = cyc;
      end
      in_data = 6'(nacc[0] + 1);
      tick();
    end
    in_valid = 1'b0;
    total++; if (done_cyc[0] < 0 || nc[0] != 2 || nc[1] != 2) begin bad++; $display("FAIL basic_timeout done_cyc=%0d words_a=%0d words_b=%0d exp=2", done_cyc[0], nc[0], nc[1]); end
    else begin
      total++; if (wd[0][0] !== {6'd4, 6'd3, 6'd2, 6'd1}) begin bad++; $display("FAIL basic_w0 got=%h exp=%h", wd[0][0], {6'd4, 6'd3, 6'd2, 6'd1}); end
      total++; if (wd[0][1] !== {6'd8, 6'd7, 6'd6, 6'd5}) begin bad++; $display("FAIL basic_w1 got=%h exp=%h", wd[0][1], {6'd8, 6'd7, 6'd6, 6'd5}); end
      total++; if ({wl[0][0], wl[0][1]} !== 2'b01) begin bad++; $display("FAIL basic_last got=%b exp=01", {wl[0][0], wl[0][1]}); end
      total++; if (ov_cyc[0][0] - s_cyc !== LN + 1) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", ov_cyc[0][0] - s_cyc, LN + 1); end
      total++; if (ov_cyc[0][1] - ov_cyc[0][0] !== LN + 1) begin bad++; $display("FAIL basic_rate got=%0d exp=%0d", ov_cyc[0][1] - ov_cyc[0][0], LN + 1); end
      total++; if (done_cyc[0] - ov_cyc[0][1] !== 1) begin bad++; $display("FAIL basic_done_lat got=%0d exp=1", done_cyc[0] - ov_cyc[0][1]); end
      total++; if (sc_a !== 4'd8) begin bad++; $display("FAIL basic_cnt_a got=%0d exp=8", sc_a); end
      total++; if (wd[1][0] !== {6'd4, 6'd3, 6'd2, 6'd1}) begin bad++; $display("FAIL part_w0 got=%h exp=%h", wd[1][0], {6'd4, 6'd3, 6'd2, 6'd1}); end
      total++; if (wd[1][1] !== {6'd0, 6'd0, 6'd6, 6'd5}) begin bad++; $display("FAIL part_w1 got=%h exp=%h", wd[1][1], {6'd0, 6'd0, 6'd6, 6'd5}); end
      total++; if ({wl[1][0], wl[1][1]} !== 2'b01) begin bad++; $display("FAIL part_last got=%b exp=01", {wl[1][0], wl[1][1]}); end
      total++; if ({sc_b, done[1], busy[1]} !== {3'd6, 1'b1, 1'b0}) begin bad++; $display("FAIL part_end cnt=%0d done=%b busy=%b exp cnt=6 done=1 busy=0", sc_b, done[1], busy[1]); end
`ifdef WEIGHT_PACKER_CHECKSUM_EN
      total++; if (cs[0] !== 16'd36) begin bad++; $display("FAIL basic_csum_a got=%0d exp=36", cs[0]); end
      total++; if (cs[1] !== 16'd21) begin bad++; $display("FAIL basic_csum_b got=%0d exp=21", cs[1]); end
`endif
    end
  endtask

  task automatic test_hold();
    logic [5:0]  dd [8];
    logic [23:0] w0, w1;
    logic        got;
    for (int k = 0; k < 8; k++) dd[k] = 6'($urandom_range(0, 63));
    w0 = {dd[3], dd[2], dd[1], dd[0]};
    w1 = {dd[7], dd[6], dd[5], dd[4]};
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 20 && !ov[0]; i++) begin
      in_data = (nacc[0] < 8) ? dd[nacc[0]] : 6'd0;
      tick();
    end
    total++; if (ov[0] !== 1'b1 || od[0] !== w0) begin bad++; $display("FAIL hold_w0 valid=%b got=%h exp=%h", ov[0], od[0], w0); end
    for (int i = 0; i < 5; i++) begin
      in_data = dd[4];
      tick();
      total++; if ({ov[0], irdy[0], od[0], sc_a} !== {1'b1, 1'b0, w0, 4'd4}) begin bad++; $display("FAIL hold_stall i=%0d valid=%b rdy=%b data=%h cnt=%0d exp valid=1 rdy=0 data=%h cnt=4", i, ov[0], irdy[0], od[0], sc_a, w0); end
    end
    out_ready = 1'b1; got = 1'b0;
    for (int i = 0; i < 30 && !done[0]; i++) begin
      if (ov[0] && nw[0] == 1) begin
        got = 1'b1;
        total++; if ({od[0], last[0]} !== {w1, 1'b1}) begin bad++; $display("FAIL hold_w1 got=%h last=%b exp=%h last=1", od[0], last[0], w1); end
      end
      in_data = (nacc[0] < 8) ? dd[nacc[0]] : 6'd0;
      tick();
    end
    in_valid = 1'b0;
    total++; if (!got || done[0] !== 1'b1 || sc_a !== 4'd8) begin bad++; $display("FAIL hold_end seen_w1=%b done=%b cnt=%0d exp seen_w1=1 done=1 cnt=8", got, done[0], sc_a); end
  endtask

  task automatic test_random();
    bit fin;
    bit e_act, e_pend;
    for (int ld = 0; ld < 8; ld++) begin
      start = 1'b1; in_valid = 1'b0;
      tick();
      start = 1'b0; fin = 1'b0;
      for (int i = 0; i < 300 && !fin; i++) begin
        for (int d = 0; d < 2; d++) begin
          e_act = m_active(d); e_pend = m_pending(d);
          total++; if ({ov[d], irdy[d], busy[d], done[d]} !== {e_pend, e_act && !e_pend, e_act, started[d] && !e_act}) begin bad++; $display("FAIL rnd_flags d=%0d got=%b exp=%b", d, {ov[d], irdy[d], busy[d], done[d]}, {e_pend, e_act && !e_pend, e_act, started[d] && !e_act}); end
          total++; if (scv(d) !== nacc[d]) begin bad++; $display("FAIL rnd_cnt d=%0d got=%0d exp=%0d", d, scv(d), nacc[d]); end
          if (e_pend) begin
            total++; if ({od[d], last[d]} !== {m_word(d), nw[d] == nwords(d) - 1}) begin bad++; $display("FAIL rnd_word d=%0d got=%h/%b exp=%h/%b", d, od[d], last[d], m_word(d), nw[d] == nwords(d) - 1); end
          end
`ifdef WEIGHT_PACKER_CHECKSUM_EN
          total++; if (cs[d] !== 16'(sum[d])) begin bad++; $display("FAIL rnd_csum d=%0d got=%0d exp=%0d", d, cs[d], 16'(sum[d])); end
`endif
        end
        fin = !m_active(0) && !m_active(1);
        in_valid  = ($urandom_range(0, 2) != 0);
        in_data   = 6'($urandom_range(0, 63));
        out_ready = ($urandom_range(0, 3) != 0);
        start     = m_active(0) && m_active(1) && ($urandom_range(0, 15) == 0);
        tick();
      end
      start = 1'b0; in_valid = 1'b0;
      total++; if (!fin) begin bad++; $display("FAIL rnd_timeout load=%0d got=unfinished exp=finished", ld); end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_mid_reset();
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10 && nacc[0] < 3; i++) begin
      in_data = 6'(nacc[0] + 1);
      tick();
    end
    rst_n = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++; if ({ov[d], irdy[d], last[d], busy[d], done[d], od[d]} !== 29'b0 || scv(d) !== 0) begin bad++; $display("FAIL midrst d=%0d flags=%b data=%h cnt=%0d exp all 0", d, {ov[d], irdy[d], last[d], busy[d], done[d]}, od[d], scv(d)); end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    test_basic();
  endtask

  task automatic test_start_ignored();
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10 && nacc[0] < 2; i++) begin
      in_data = 6'(nacc[0] + 1);
      tick();
    end
    start = 1'b1; in_data = 6'd3;
    tick();
    start = 1'b0;
    total++; if ({sc_a, sc_b, busy, irdy} !== {4'd3, 3'd3, 2'b11, 2'b11}) begin bad++; $display("FAIL ign_fill cnt_a=%0d cnt_b=%0d busy=%b rdy=%b exp 3 3 11 11", sc_a, sc_b, busy, irdy); end
    for (int i = 0; i < 30 && !done[0]; i++) begin
      in_data = 6'(nacc[0] + 1);
      tick();
    end
    total++; if ({done[0], sc_a} !== {1'b1, 4'd8}) begin bad++; $display("FAIL ign_done done=%b cnt=%0d exp done=1 cnt=8", done[0], sc_a); end
    start = 1'b1; in_valid = 1'b1; in_data = 6'h2a;
    tick();
    start = 1'b0; in_valid = 1'b0;
    total++; if ({sc_a, irdy[0], busy[0], done[0]} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin bad++; $display("FAIL ign_coinc cnt=%0d rdy=%b busy=%b done=%b exp cnt=0 rdy=1 busy=1 done=0", sc_a, irdy[0], busy[0], done[0]); end
    tick();
    total++; if ({sc_a, sc_b} !== {4'd0, 3'd0}) begin bad++; $display("FAIL ign_idle cnt_a=%0d cnt_b=%0d exp 0 0", sc_a, sc_b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_random();
    test_mid_reset();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
